mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port RAM between the CPU instruction-fetch path and the CPU load/store path, so program and data can live in one memory.
- Grants one requester per access and forwards its address, write data and mask to the memory.
- Tracks the single outstanding read and routes returned data back to the requester that issued it.
- Sits between cpu and the unified ram; it is the only driver of the memory's control inputs.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- DATA_WIDTH, 32, width of all data ports.
- READ_LATENCY, 1, cycles from the grant edge to valid mem_rdata; legal range 1..7.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- if_req  input  1  fetch read request
- if_addr  input  ADDR_WIDTH  fetch address
- if_gnt  output  1  fetch request accepted this cycle
- if_rvalid  output  1  fetch read data valid (1-cycle pulse)
- if_rdata  output  DATA_WIDTH  fetch read data
- d_req  input  1  data access request
- d_we  input  1  1 = write, 0 = read
- d_addr  input  ADDR_WIDTH  data address
- d_wdata  input  DATA_WIDTH  write data
- d_mask  input  memory_mask_t  access size (byte/halfword/word)
- d_gnt  output  1  data request accepted this cycle
- d_rvalid  output  1  load data valid (1-cycle pulse)
- d_rdata  output  DATA_WIDTH  load data
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_mask  output  memory_mask_t  memory access size
- mem_rdata  input  DATA_WIDTH  memory read data
- busy  output  1  a read is outstanding

Behaviour:
- Reset values: state IDLE, all gnt/rvalid 0, mem_en 0, mem_we 0, busy 0, mem_addr/mem_wdata 0, mem_mask MEM_WORD, if_rdata/d_rdata 0, last-owner = fetch, latency counter 0.
- FSM has two states, IDLE and WAIT.
- IDLE, no request: mem_en = 0.
- IDLE with a request:
  - Select the owner.
  - Assert the owner's gnt combinationally in the same cycle, with mem_en = 1 and mem_addr/mem_we/mem_wdata/mem_mask taken from the owner.
  - Fetch drives mem_we = 0, mem_mask = MEM_WORD, mem_wdata = 0.
- Write grant: completes in the grant cycle; no rvalid is produced; state stays IDLE, so the next grant can be issued the following cycle.
- Read grant:
  - Register the owner.
  - Load the counter with READ_LATENCY-1 and go to WAIT.
  - busy = 1 from the next cycle.
- WAIT:
  - No gnt is asserted; mem_en = 0.
  - Counter decrements each cycle.
  - In the cycle the counter is 0 (grant cycle + READ_LATENCY), assert the owner's rvalid.
  - In that cycle, the owner's rdata = mem_rdata (combinational pass-through), and it is latched so rdata holds that value until that port's next rvalid.
  - Go to IDLE.
- Back-to-back: in the rvalid cycle, IDLE arbitration is also evaluated in the same cycle (WAIT→IDLE merged). A pending request is granted there, giving sustained read throughput of 1 per READ_LATENCY cycles.
- Priority (default): data beats fetch when both are requesting.
- A requester must hold req and its address stable until gnt. Dropping req before gnt is legal; no access occurs.
- The non-owner's rvalid is never asserted. The non-owner's rdata is unchanged.
- last-owner updates on every grant.
- Reset asserted mid-read: the outstanding read is discarded, no rvalid is produced, and all reset values apply immediately (asynchronous).
- READ_LATENCY outside 1..7: elaboration error via $error in an initial/generate check.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both ports request in IDLE, grant the port that is not last-owner. A single requester is always granted.
- Undefined: fixed data-over-fetch priority; last-owner is still tracked but is unused for selection.

Test Plan:
- Reset, then if_req=1 with if_addr=0x10, READ_LATENCY=1, memory returns 0xDEADBEEF:
  - if_gnt in cycle 0.
  - if_rvalid=1 and if_rdata=0xDEADBEEF in cycle 1.
  - if_rdata holds 0xDEADBEEF after that.
- d_req=1, d_we=1, d_addr=0x100, d_wdata=0x12345678, d_mask=MEM_BYTE:
  - d_gnt, mem_en=1, mem_we=1, mem_mask=MEM_BYTE in the same cycle.
  - No d_rvalid.
  - busy stays 0.
- if_req and d_req (read) held together, READ_LATENCY=3:
  - Without the macro: d_gnt at cycle 0, d_rvalid at cycle 3, if_gnt at cycle 3, if_rvalid at cycle 6.
  - With MEM_ARB_ROUND_ROBIN_EN: grants alternate starting with data.
- READ_LATENCY=2, continuous if_req with addresses 0,4,8: if_gnt at cycles 0,2,4 and if_rvalid at cycles 2,4,6.
- Fetch read granted, rst pulsed for 1 cycle in the WAIT state:
  - No if_rvalid.
  - busy=0 and if_rdata=0 immediately.
  - The next request is granted normally.
- While in WAIT, raise d_req: d_gnt stays 0 until the rvalid cycle, then the data request is granted in that cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and load/store, tracking one outstanding read.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of data-over-fetch priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_mask,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_mask,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
        $error("mem_arbiter: READ_LATENCY must be within 1..7");
    end

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, d_rdata_q;

    logic rd_done;
    logic arb_en;
    logic data_first;
    logic pick_data;

    // The rvalid cycle doubles as an IDLE cycle so reads can issue back to back.
    assign rd_done = (state_q == WAIT) && (cnt_q == 3'd0);
    assign arb_en  = (state_q == IDLE) || rd_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign data_first = (last_owner_q == OWN_FETCH);
`else
    assign data_first = 1'b1;
`endif

    assign pick_data = d_req && (!if_req || data_first);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        if_rvalid    = 1'b0;
        d_rvalid     = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_mask     = MEM_WORD;

        if (state_q == WAIT) begin
            if (rd_done) begin
                state_d = IDLE;
                if (owner_q == OWN_DATA) d_rvalid = 1'b1;
                else                     if_rvalid = 1'b1;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end

        if (arb_en && (if_req || d_req)) begin
            mem_en       = 1'b1;
            last_owner_d = pick_data;
            if (pick_data) begin
                d_gnt     = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_mask  = d_mask;
            end else begin
                if_gnt   = 1'b1;
                mem_addr = if_addr;
            end
            // Writes finish in the grant cycle; only reads occupy the WAIT state.
            if (!(pick_data && d_we)) begin
                state_d = WAIT;
                owner_d = pick_data;
                cnt_d   = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_FETCH;
            last_owner_q <= OWN_FETCH;
            cnt_q        <= 3'd0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            if (if_rvalid) if_rdata_q <= mem_rdata;
            if (d_rvalid)  d_rdata_q  <= mem_rdata;
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata  = d_rvalid  ? mem_rdata : d_rdata_q;
    assign busy     = (state_q == WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter, checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RL = 3;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    mask;
    } dreq_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [1:0]    d_mask = MEM_WORD;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_mask;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_mask   (d_mask),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_mask (mem_mask),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Pending requests per port; the head is what the requester is presenting.
    logic [AW-1:0] if_q[$];
    dreq_t         d_q[$];

    // Transaction-level model: when the memory is free again and which read is in flight.
    int            cyc;
    int            free_at;
    int            rv_at;
    bit            rv_pend;
    bit            rv_port;      // 0 = fetch, 1 = data
    bit            last_owner;   // 0 = fetch, 1 = data
    bit            force_rd;
    logic [DW-1:0] force_val;
    logic [DW-1:0] rv_data;
    logic [DW-1:0] exp_if_rdata;
    logic [DW-1:0] exp_d_rdata;

    function automatic dreq_t mk_d(logic we, logic [AW-1:0] addr, logic [DW-1:0] wdata, logic [1:0] mask);
        dreq_t r;
        r.we = we;
        r.addr = addr;
        r.wdata = wdata;
        r.mask = mask;
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
        #1;
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_mask", mem_mask, MEM_WORD);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        free_at = 0;
        rv_pend = 1'b0;
        last_owner = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata = '0;
        if_q.delete();
        d_q.delete();
    endtask

    task automatic run_cycle();
        dreq_t         dcur;
        bit            rv_now, g_d, g_if;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        logic [1:0]    em;
        logic          ewe;

        @(posedge clk);
        #1;
        if_req = (if_q.size() != 0);
        if_addr = if_req ? if_q[0] : AW'($urandom);
        d_req = (d_q.size() != 0);
        dcur = d_req ? d_q[0] : mk_d(1'($urandom), AW'($urandom), DW'($urandom), 2'($urandom_range(0, 2)));
        d_we = dcur.we;
        d_addr = dcur.addr;
        d_wdata = dcur.wdata;
        d_mask = dcur.mask;
        rv_now = rv_pend && (rv_at == cyc);
        mem_rdata = rv_now ? rv_data : DW'($urandom);
        @(negedge clk);

        g_d = 1'b0;
        g_if = 1'b0;
        if (cyc >= free_at) begin
            if (d_req && if_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                g_d = (last_owner == 1'b0);
`else
                g_d = 1'b1;
`endif
                g_if = !g_d;
            end else begin
                g_d = d_req;
                g_if = if_req;
            end
        end
        ewe = g_d ? dcur.we : 1'b0;
        ea  = g_d ? dcur.addr : if_addr;
        ew  = g_d ? dcur.wdata : '0;
        em  = g_d ? dcur.mask : MEM_WORD;

        chk("if_gnt", if_gnt, g_if);
        chk("d_gnt", d_gnt, g_d);
        chk("mem_en", mem_en, g_d | g_if);
        if (g_d || g_if) begin
            chk("mem_we", mem_we, ewe);
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ew);
            chk("mem_mask", mem_mask, em);
        end
        chk("if_rvalid", if_rvalid, rv_now && !rv_port);
        chk("d_rvalid", d_rvalid, rv_now && rv_port);
        chk("if_rdata", if_rdata, (rv_now && !rv_port) ? rv_data : exp_if_rdata);
        chk("d_rdata", d_rdata, (rv_now && rv_port) ? rv_data : exp_d_rdata);
        chk("busy", busy, rv_pend);

        if (rv_now) begin
            if (rv_port) exp_d_rdata = rv_data;
            else         exp_if_rdata = rv_data;
            rv_pend = 1'b0;
        end
        if (g_d || g_if) begin
            last_owner = g_d;
            if (g_d) void'(d_q.pop_front());
            else     void'(if_q.pop_front());
            if (ewe) begin
                free_at = cyc + 1;
            end else begin
                rv_pend = 1'b1;
                rv_port = g_d;
                rv_at = cyc + RL;
                rv_data = force_rd ? force_val : DW'($urandom);
                force_rd = 1'b0;
                free_at = cyc + RL;
            end
        end
        cyc++;
    endtask

    initial begin
        force_rd = 1'b0;
        force_val = '0;
        rv_data = '0;
        rv_port = 1'b0;
        rv_at = 0;
        do_reset();

        // Single fetch read returning a known word.
        force_rd = 1'b1;
        force_val = 32'hDEADBEEF;
        if_q.push_back(32'h10);
        repeat (RL + 3) run_cycle();

        // Byte write: single-cycle, no rvalid, never busy.
        d_q.push_back(mk_d(1'b1, 32'h100, 32'h12345678, MEM_BYTE));
        repeat (3) run_cycle();

        // Contending reads from both ports.
        d_q.push_back(mk_d(1'b0, 32'h200, 32'h0, MEM_WORD));
        if_q.push_back(32'h20);
        repeat (2 * RL + 3) run_cycle();

        // Continuous fetch stream.
        if_q.push_back(32'h0);
        if_q.push_back(32'h4);
        if_q.push_back(32'h8);
        repeat (3 * RL + 3) run_cycle();

        // Data request raised while a fetch read is outstanding.
        if_q.push_back(32'h30);
        run_cycle();
        d_q.push_back(mk_d(1'b0, 32'h300, 32'h0, MEM_HALF));
        repeat (2 * RL + 3) run_cycle();

        // Reset in the middle of a fetch read, then a normal request.
        if_q.push_back(32'h40);
        run_cycle();
        run_cycle();
        do_reset();
        if_q.push_back(32'h44);
        repeat (RL + 3) run_cycle();

        // Random traffic, including requests withdrawn before grant.
        repeat (300) begin
            if (if_q.size() == 0 && $urandom_range(0, 2) == 0)
                if_q.push_back(AW'($urandom) & ~AW'(3));
            if (d_q.size() == 0 && $urandom_range(0, 2) == 0)
                d_q.push_back(mk_d(1'($urandom), AW'($urandom), DW'($urandom), 2'($urandom_range(0, 2))));
            if (if_q.size() != 0 && $urandom_range(0, 15) == 0) void'(if_q.pop_front());
            if (d_q.size() != 0 && $urandom_range(0, 15) == 0) void'(d_q.pop_front());
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
